// File: rtl/mem_pkg.sv
// Shared types and constants for the data RAM response block.
// Holds the FSM state type, parameter defaults and the illegal-read return value.
package mem_pkg;

    localparam int ADDR_W_DEF   = 10;
    localparam int WAIT_CYC_DEF = 2;

    localparam logic [31:0] ILLEGAL_RDATA = 32'h0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage : mem_pkg

// File: rtl/sp_ram.sv
// Single-port word array: synchronous write, combinational read.
// Contents are deliberately not reset so data survives a block reset.
module sp_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_array [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_array[addr] <= wdata;
        end
    end

    assign rdata = mem_array[addr];

endmodule : sp_ram

// File: rtl/data_ram_resp.sv
// Data RAM front end: accepts M-stage accesses, inserts WAIT_CYC read wait cycles,
// drops/flags misaligned or out-of-range accesses and registers read data.
module data_ram_resp
    import mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int WAIT_CYC = WAIT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_ram_ena_M,
    input  logic        data_ram_wea_M,
    input  logic [31:0] alu_result_M,
    input  logic [31:0] mem_wdata_M,
    output logic [31:0] mem_rdata_M,
    output logic        mem_busy,
    output logic        addr_err
);

    localparam logic [2:0] CNT_INIT = (WAIT_CYC > 0) ? 3'(WAIT_CYC - 1) : 3'd0;

    state_t              state_reg;
    logic [2:0]          cnt_reg;
    logic [31:0]         rdata_reg;
    logic                err_reg;
    logic [ADDR_W-1:0]   lat_addr_reg;
    logic                lat_bad_reg;

    logic [ADDR_W-1:0]   req_addr;
    logic                req_bad;
    logic                accept;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [31:0]         ram_rdata;

    // Upper bits are checked by shifting so no address ever aliases into the array.
    assign req_addr = alu_result_M[ADDR_W+1:2];
    assign req_bad  = (alu_result_M[1:0] != 2'b00) ||
                      ((alu_result_M >> (ADDR_W + 2)) != 32'd0);
    assign accept   = (state_reg == IDLE) && data_ram_ena_M && !rst;
    assign ram_we   = accept && data_ram_wea_M && !req_bad;
    assign ram_addr = (state_reg == WAIT) ? lat_addr_reg : req_addr;

    sp_ram #(
        .ADDR_W (ADDR_W)
    ) u_sp_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (mem_wdata_M),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= 3'd0;
            rdata_reg    <= 32'h0;
            err_reg      <= 1'b0;
            lat_addr_reg <= '0;
            lat_bad_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (data_ram_ena_M) begin
                        if (req_bad) begin
                            err_reg <= 1'b1;
                        end
                        if (!data_ram_wea_M) begin
                            if (WAIT_CYC == 0) begin
                                rdata_reg <= req_bad ? ILLEGAL_RDATA : ram_rdata;
                            end else begin
                                state_reg    <= WAIT;
                                cnt_reg      <= CNT_INIT;
                                lat_addr_reg <= req_addr;
                                lat_bad_reg  <= req_bad;
                            end
                        end
                    end
                end
                WAIT: begin
                    // Array is read at the completion edge so earlier writes are visible.
                    if (cnt_reg == 3'd0) begin
                        rdata_reg <= lat_bad_reg ? ILLEGAL_RDATA : ram_rdata;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem_rdata_M = rdata_reg;
    assign mem_busy    = (state_reg == WAIT);
    assign addr_err    = err_reg;

endmodule : data_ram_resp

// File: tb/tb_data_ram_resp.sv
// Directed bench for data_ram_resp: one instance with zero wait states, one with three.
module tb_data_ram_resp;

    logic        clk;
    logic        rst;

    logic        ena0, wea0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        busy0, err0;

    logic        ena3, wea3;
    logic [31:0] addr3, wdata3, rdata3;
    logic        busy3, err3;

    int checks = 0;
    int errors = 0;

    data_ram_resp #(.ADDR_W(10), .WAIT_CYC(0)) dut0 (
        .clk            (clk),
        .rst            (rst),
        .data_ram_ena_M (ena0),
        .data_ram_wea_M (wea0),
        .alu_result_M   (addr0),
        .mem_wdata_M    (wdata0),
        .mem_rdata_M    (rdata0),
        .mem_busy       (busy0),
        .addr_err       (err0)
    );

    data_ram_resp #(.ADDR_W(10), .WAIT_CYC(3)) dut3 (
        .clk            (clk),
        .rst            (rst),
        .data_ram_ena_M (ena3),
        .data_ram_wea_M (wea3),
        .alu_result_M   (addr3),
        .mem_wdata_M    (wdata3),
        .mem_rdata_M    (rdata3),
        .mem_busy       (busy3),
        .addr_err       (err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-18s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Single-cycle request on the zero-wait instance.
    task automatic req0(input logic we, input logic [31:0] a, input logic [31:0] d);
        ena0 = 1'b1; wea0 = we; addr0 = a; wdata0 = d;
        tick();
        ena0 = 1'b0; wea0 = 1'b0;
    endtask

    task automatic req3(input logic we, input logic [31:0] a, input logic [31:0] d);
        ena3 = 1'b1; wea3 = we; addr3 = a; wdata3 = d;
        tick();
        ena3 = 1'b0; wea3 = 1'b0;
    endtask

    // Wait-state read: busy must be high for exactly three cycles, data on the falling edge.
    task automatic read3(input string tag, input logic [31:0] a, input logic [31:0] exp);
        req3(1'b0, a, 32'h0);
        check({tag, "_busy1"}, {31'd0, busy3}, 32'd1);
        tick();
        check({tag, "_busy2"}, {31'd0, busy3}, 32'd1);
        tick();
        check({tag, "_busy3"}, {31'd0, busy3}, 32'd1);
        tick();
        check({tag, "_busy0"}, {31'd0, busy3}, 32'd0);
        check({tag, "_data"}, rdata3, exp);
    endtask

    initial begin
        rst = 1'b1;
        ena0 = 1'b0; wea0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
        ena3 = 1'b0; wea3 = 1'b0; addr3 = 32'h0; wdata3 = 32'h0;
        tick();
        tick();
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_busy0", {31'd0, busy0}, 32'd0);
        check("rst_err0", {31'd0, err0}, 32'd0);
        check("rst_rdata3", rdata3, 32'h0);
        check("rst_busy3", {31'd0, busy3}, 32'd0);
        check("rst_err3", {31'd0, err3}, 32'd0);
        rst = 1'b0;
        tick();

        // Write then read, zero wait
        req0(1'b1, 32'h10, 32'hDEADBEEF);
        check("w0_busy", {31'd0, busy0}, 32'd0);
        check("w0_rdata_hold", rdata0, 32'h0);
        req0(1'b0, 32'h10, 32'h0);
        check("r0_data", rdata0, 32'hDEADBEEF);
        check("r0_busy", {31'd0, busy0}, 32'd0);

        // Back-to-back writes then reads
        req0(1'b1, 32'h0, 32'd1);
        check("bb_busy_a", {31'd0, busy0}, 32'd0);
        req0(1'b1, 32'h4, 32'd2);
        check("bb_busy_b", {31'd0, busy0}, 32'd0);
        req0(1'b1, 32'h8, 32'd3);
        check("bb_busy_c", {31'd0, busy0}, 32'd0);
        check("bb_rdata_hold", rdata0, 32'hDEADBEEF);
        req0(1'b0, 32'h0, 32'h0);
        check("bb_rd0", rdata0, 32'd1);
        req0(1'b0, 32'h4, 32'h0);
        check("bb_rd4", rdata0, 32'd2);
        req0(1'b0, 32'h8, 32'h0);
        check("bb_rd8", rdata0, 32'd3);
        tick();
        check("hold_idle", rdata0, 32'd3);

        // Out-of-range read, then a legal access keeps the sticky flag
        check("oor_err_pre", {31'd0, err0}, 32'd0);
        req0(1'b0, 32'h1000, 32'h0);
        check("oor_data", rdata0, 32'h0);
        check("oor_err", {31'd0, err0}, 32'd1);
        req0(1'b0, 32'h10, 32'h0);
        check("oor_legal_data", rdata0, 32'hDEADBEEF);
        check("oor_err_sticky", {31'd0, err0}, 32'd1);

        // Wait-state read; a write issued while busy must be ignored
        req3(1'b1, 32'h20, 32'h12345678);
        check("w3_busy", {31'd0, busy3}, 32'd0);
        req3(1'b0, 32'h20, 32'h0);
        check("ws_busy1", {31'd0, busy3}, 32'd1);
        ena3 = 1'b1; wea3 = 1'b1; addr3 = 32'h20; wdata3 = 32'h00000BAD;
        tick();
        check("ws_busy2", {31'd0, busy3}, 32'd1);
        check("ws_data_hold", rdata3, 32'h0);
        tick();
        check("ws_busy3", {31'd0, busy3}, 32'd1);
        tick();
        ena3 = 1'b0; wea3 = 1'b0;
        check("ws_busy_fall", {31'd0, busy3}, 32'd0);
        check("ws_data", rdata3, 32'h12345678);
        read3("ws_noclobber", 32'h20, 32'h12345678);

        // Misaligned write is dropped and flagged
        req3(1'b1, 32'h21, 32'hFFFFFFFF);
        check("mis_err", {31'd0, err3}, 32'd1);
        check("mis_busy", {31'd0, busy3}, 32'd0);
        read3("mis_rd", 32'h20, 32'h12345678);

        // Reset one cycle after a read is accepted aborts it
        req3(1'b0, 32'h20, 32'h0);
        check("rm_busy", {31'd0, busy3}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rm_busy_clr", {31'd0, busy3}, 32'd0);
        check("rm_rdata_clr", rdata3, 32'h0);
        check("rm_err_clr", {31'd0, err3}, 32'd0);
        tick();
        tick();
        tick();
        check("rm_no_deliver", rdata3, 32'h0);
        read3("rm_array_kept", 32'h20, 32'h12345678);

        // A request coincident with reset is ignored
        rst = 1'b1;
        req3(1'b1, 32'h20, 32'h55555555);
        rst = 1'b0;
        check("rr_busy", {31'd0, busy3}, 32'd0);
        read3("rr_rd", 32'h20, 32'h12345678);

        // Illegal read with wait states: normal timing, zero data
        read3("ill_rd", 32'h1000, 32'h0);
        check("ill_err", {31'd0, err3}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_data_ram_resp
